uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver's done/clear handshake on the receive path. Captures each received byte into a small first-word-fall-through FIFO and presents it to the consumer on a valid/ready interface. Counts bytes dropped because the FIFO was full. Sits between the UART receiver and the byte consumer (command parser, bus bridge).

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, minimum 2
ADDR_W, 3, log2(DEPTH)
OVR_W, 8, overrun counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  allows new captures; 0 = ignore rx_done in IDLE
rx_data  in  8  byte from receiver, stable while rx_done=1
rx_done  in  1  receiver byte-complete flag, level, held until cleared
rx_clear  out  1  clear request to receiver
m_data  out  8  FIFO head byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data
level  out  ADDR_W+1  FIFO occupancy, 0..DEPTH
overrun_cnt  out  OVR_W  bytes dropped while full, saturating
ovr_clr  in  1  zero overrun_cnt
busy  out  1  handshake in progress (state != IDLE)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; FIFO pointers and level=0; m_valid=0; rx_clear=0; busy=0; overrun_cnt=0. m_data is don't-care while m_valid=0.
- FSM states: IDLE, CLEAR, RELEASE. rx_clear = (state != IDLE), decoded from the registered state only.
- IDLE, edge where en=1 and rx_done=1:
  - capture rx_data: push if FIFO not full; otherwise drop and increment overrun_cnt.
  - go to CLEAR.
  - otherwise stay in IDLE.
- CLEAR: unconditional to RELEASE on the next edge. Guarantees rx_clear is high for at least 2 cycles.
- RELEASE: stay while rx_done=1; go to IDLE on the first edge that samples rx_done=0.
- Exactly one capture per rx_done assertion. A byte is never captured twice, even if rx_done stays high for many cycles.
- en=0 only blocks a new capture in IDLE. A handshake already in progress completes normally.
- Latency: rx_done sampled high at edge N → byte written at edge N. If the FIFO was empty, m_valid=1 and m_data=byte after edge N. rx_clear rises after edge N.
- FIFO, first-word fall-through:
  - m_valid = (level != 0); m_data = mem[rd_ptr].
  - pop = m_valid & m_ready; push as defined above.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop:
  - when full: push succeeds, level stays DEPTH, no overrun.
  - when empty: pop is impossible (m_valid=0), level becomes 1.
- Level update: push only +1; pop only -1; both or neither, unchanged.
- overrun_cnt saturates at all ones. If ovr_clr and an overrun occur in the same cycle, ovr_clr wins and the result is 0.
- Reset mid-handshake: FSM returns to IDLE, rx_clear drops, FIFO flushed. If the receiver still holds rx_done=1 after reset and en=1, that byte is captured again (permitted).
- m_data must not change while m_valid=1 and m_ready=0.

Test Plan:
- Single byte: rx_data=8'hA5 with rx_done held 1 for 3 cycles, en=1, m_ready=0 → one push, level=1, m_valid=1, m_data=A5, rx_clear high from edge N to the edge sampling rx_done=0, busy tracks rx_clear.
- Burst order: 8 bytes 01..08, each handshake completed, m_ready=0 → level=8. Then m_ready=1 → m_data yields 01..08 in order, one per cycle, then m_valid=0.
- Overrun: FIFO full (DEPTH=8), 3 more bytes arrive → overrun_cnt=3, FIFO contents unchanged, rx_clear still issued for each byte. Pulse ovr_clr → overrun_cnt=0.
- Full with simultaneous pop: level=8, m_ready=1 on the same edge as capture of 8'h5A → level stays 8, overrun_cnt unchanged, 5A read out last.
- en gating: en=0 with rx_done=1 for 10 cycles → no push, rx_clear=0. Raise en → exactly one capture and handshake.
- Reset mid-operation: rst=1 while in RELEASE with level=4 → after the edge, level=0, m_valid=0, rx_clear=0, overrun_cnt=0, state=IDLE.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: runs the done/clear handshake with the receiver,
// buffers bytes in a first-word-fall-through FIFO and counts bytes lost to a full FIFO.
module uart_rx_ctrl #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int OVR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   output logic              rx_clear,
   output logic [7:0]        m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ADDR_W:0]   level,
   output logic [OVR_W-1:0]  overrun_cnt,
   input  logic              ovr_clr,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, CLEAR, RELEASE} state_t;

   state_t              state_q, state_d;
   logic [7:0]          mem_q [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     level_q, level_d;
   logic [OVR_W-1:0]    ovr_q, ovr_d;
   logic                capture, full, push, pop, drop;

   assign capture = (state_q == IDLE) && en && rx_done;
   assign full    = (level_q == (ADDR_W+1)'(DEPTH));
   assign pop     = m_valid && m_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push    = capture && (!full || pop);
   assign drop    = capture && full && !pop;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture) state_d = CLEAR;
         CLEAR:   state_d = RELEASE;
         RELEASE: if (!rx_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovr_d    = ovr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      if (ovr_clr)                   ovr_d = '0;
      else if (drop && ovr_q != '1)  ovr_d = ovr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovr_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovr_q    <= ovr_d;
      end
   end

   // Storage needs no reset; contents are only visible while level is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rx_data;
   end

   assign rx_clear    = (state_q != IDLE);
   assign busy        = (state_q != IDLE);
   assign m_valid     = (level_q != '0);
   assign m_data      = mem_q[rd_ptr_q];
   assign level       = level_q;
   assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected bytes are queued as they are sent
// and compared in order as the consumer side accepts them.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 8;
   localparam int ADDR_W = 3;
   localparam int OVR_W = 8;

   logic              clk = 1'b0;
   logic              rst, en, rx_done, m_ready, ovr_clr;
   logic [7:0]        rx_data;
   logic              rx_clear, m_valid, busy;
   logic [7:0]        m_data;
   logic [ADDR_W:0]   level;
   logic [OVR_W-1:0]  overrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] q[$];

   uart_rx_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OVR_W(OVR_W)) dut (
      .clk(clk), .rst(rst), .en(en), .rx_data(rx_data), .rx_done(rx_done),
      .rx_clear(rx_clear), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .level(level), .overrun_cnt(overrun_cnt), .ovr_clr(ovr_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full receiver handshake: capture edge, CLEAR edge, then release.
   task automatic send_byte(input logic [7:0] b, input bit exp_push, output logic clr);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      clr = rx_clear;
      if (exp_push) q.push_back(b);
      tick();
      rx_done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; rx_done = 1'b0; m_ready = 1'b0; ovr_clr = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      n_tests++;
      if (level !== 4'd0 || m_valid !== 1'b0 || rx_clear !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset: level=%0d m_valid=%b rx_clear=%b busy=%b ovr=%0d, want all 0",
                  level, m_valid, rx_clear, busy, overrun_cnt);
      end
   endtask

   task automatic test_single();
      rx_data = 8'hA5; rx_done = 1'b1;
      tick();
      q.push_back(8'hA5);
      n_tests++;
      if (level !== 4'd1 || m_valid !== 1'b1 || m_data !== 8'hA5 || rx_clear !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_capture: level=%0d valid=%b data=%h clr=%b busy=%b, want 1 1 a5 1 1",
                  level, m_valid, m_data, rx_clear, busy);
      end
      repeat (2) begin
         tick();
         n_tests++;
         if (rx_clear !== 1'b1 || busy !== 1'b1 || level !== 4'd1) begin
            n_fail++;
            $display("FAIL single_hold: clr=%b busy=%b level=%0d, want 1 1 1", rx_clear, busy, level);
         end
      end
      rx_done = 1'b0;
      tick();
      n_tests++;
      if (rx_clear !== 1'b0 || busy !== 1'b0 || level !== 4'd1) begin
         n_fail++;
         $display("FAIL single_release: clr=%b busy=%b level=%0d, want 0 0 1", rx_clear, busy, level);
      end
      m_ready = 1'b1;
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== q[0]) begin
         n_fail++;
         $display("FAIL single_read: valid=%b data=%h, want 1 %h", m_valid, m_data, q[0]);
      end
      void'(q.pop_front());
      tick();
      m_ready = 1'b0;
      n_tests++;
      if (m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_empty: valid=%b, want 0", m_valid);
      end
   endtask

   task automatic test_burst();
      logic clr;
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, clr);
      n_tests++;
      if (level !== 4'd8) begin
         n_fail++;
         $display("FAIL burst_level: level=%0d, want 8", level);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== q[0]) begin
            n_fail++;
            $display("FAIL burst_order[%0d]: valid=%b data=%h, want 1 %h", i, m_valid, m_data, q[0]);
         end
         void'(q.pop_front());
         tick();
      end
      m_ready = 1'b0;
      n_tests++;
      if (m_valid !== 1'b0 || level !== 4'd0) begin
         n_fail++;
         $display("FAIL burst_drained: valid=%b level=%0d, want 0 0", m_valid, level);
      end
   endtask

   task automatic test_overrun();
      logic clr;
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, clr);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'hE0 + 8'(i), 1'b0, clr);
         n_tests++;
         if (clr !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_clear[%0d]: rx_clear=%b, want 1", i, clr);
         end
      end
      n_tests++;
      if (overrun_cnt !== 8'd3 || level !== 4'd8) begin
         n_fail++;
         $display("FAIL overrun_count: ovr=%0d level=%0d, want 3 8", overrun_cnt, level);
      end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      n_tests++;
      if (overrun_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL overrun_clr: ovr=%0d, want 0", overrun_cnt);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== q[0]) begin
            n_fail++;
            $display("FAIL overrun_contents[%0d]: valid=%b data=%h, want 1 %h", i, m_valid, m_data, q[0]);
         end
         void'(q.pop_front());
         tick();
      end
      m_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      logic clr;
      for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), 1'b1, clr);
      rx_data = 8'h5A; rx_done = 1'b1; m_ready = 1'b1;
      n_tests++;
      if (m_data !== q[0]) begin
         n_fail++;
         $display("FAIL fullpop_head: data=%h, want %h", m_data, q[0]);
      end
      void'(q.pop_front());
      q.push_back(8'h5A);
      tick();
      m_ready = 1'b0;
      n_tests++;
      if (level !== 4'd8 || overrun_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL fullpop_level: level=%0d ovr=%0d, want 8 0", level, overrun_cnt);
      end
      tick();
      rx_done = 1'b0;
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== q[0]) begin
            n_fail++;
            $display("FAIL fullpop_order[%0d]: valid=%b data=%h, want 1 %h", i, m_valid, m_data, q[0]);
         end
         void'(q.pop_front());
         tick();
      end
      m_ready = 1'b0;
   endtask

   task automatic test_en_gating();
      int bad = 0;
      en = 1'b0; rx_data = 8'hC3; rx_done = 1'b1;
      repeat (10) begin
         tick();
         if (rx_clear !== 1'b0 || level !== 4'd0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL en_block: %0d bad cycles, want 0", bad);
      end
      en = 1'b1;
      tick();
      q.push_back(8'hC3);
      n_tests++;
      if (level !== 4'd1 || rx_clear !== 1'b1) begin
         n_fail++;
         $display("FAIL en_capture: level=%0d clr=%b, want 1 1", level, rx_clear);
      end
      repeat (4) tick();
      n_tests++;
      if (level !== 4'd1 || rx_clear !== 1'b1) begin
         n_fail++;
         $display("FAIL en_once: level=%0d clr=%b, want 1 1", level, rx_clear);
      end
      rx_done = 1'b0;
      tick();
      m_ready = 1'b1;
      n_tests++;
      if (rx_clear !== 1'b0 || m_data !== q[0]) begin
         n_fail++;
         $display("FAIL en_done: clr=%b data=%h, want 0 %h", rx_clear, m_data, q[0]);
      end
      void'(q.pop_front());
      tick();
      m_ready = 1'b0;
   endtask

   task automatic test_ovr_sat();
      logic clr;
      for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i), 1'b1, clr);
      for (int i = 0; i < 260; i++) send_byte(8'hEE, 1'b0, clr);
      n_tests++;
      if (overrun_cnt !== 8'hFF) begin
         n_fail++;
         $display("FAIL ovr_saturate: ovr=%0d, want 255", overrun_cnt);
      end
      rx_data = 8'hEF; rx_done = 1'b1; ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      n_tests++;
      if (overrun_cnt !== 8'd0 || level !== 4'd8) begin
         n_fail++;
         $display("FAIL ovr_clr_wins: ovr=%0d level=%0d, want 0 8", overrun_cnt, level);
      end
      tick();
      rx_done = 1'b0;
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== q[0]) begin
            n_fail++;
            $display("FAIL ovr_contents[%0d]: valid=%b data=%h, want 1 %h", i, m_valid, m_data, q[0]);
         end
         void'(q.pop_front());
         tick();
      end
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic clr;
      for (int i = 0; i < 8; i++) send_byte(8'h70 + 8'(i), 1'b1, clr);
      send_byte(8'hEE, 1'b0, clr);
      m_ready = 1'b1;
      repeat (5) begin
         void'(q.pop_front());
         tick();
      end
      m_ready = 1'b0;
      rx_data = 8'h99; rx_done = 1'b1;
      tick();
      tick();
      n_tests++;
      if (level !== 4'd4 || busy !== 1'b1 || overrun_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL mid_setup: level=%0d busy=%b ovr=%0d, want 4 1 1", level, busy, overrun_cnt);
      end
      rst = 1'b1; rx_done = 1'b0;
      tick();
      rst = 1'b0;
      q.delete();
      n_tests++;
      if (level !== 4'd0 || m_valid !== 1'b0 || rx_clear !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_reset: level=%0d valid=%b clr=%b busy=%b ovr=%0d, want all 0",
                  level, m_valid, rx_clear, busy, overrun_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overrun();
      test_full_pop();
      test_en_gating();
      test_ovr_sat();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
